// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEF_MEM_DEPTH = 200;
  localparam int DEF_READ_LAT  = 2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // One-hot grant; on a tie the port not served last wins
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[PORT_D] ? PORT_D : PORT_IF;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register; reset favours the fetch port on the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= PORT_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int READ_LAT  = DEF_READ_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_adress,
  output logic [31:0] mem_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_out,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        win_q, win_d;
  logic        err_q, err_d;
  logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0] mem_adress_q, mem_adress_d, mem_data_q, mem_data_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        busy_q, busy_d;

  logic [1:0]  gnt_s;
  logic        grant_s, sel_d_s, in_range_s, rd_done_s;
  logic [31:0] sel_addr_s;

  // The ack cycle doubles as the idle bubble, so a still-high req is not re-granted
  assign grant_s    = (state_q == IDLE) && !if_ack_q && !d_ack_q && (if_req || d_req);
  assign sel_d_s    = gnt_s[PORT_D];
  assign sel_addr_s = sel_d_s ? d_addr : if_addr;
  assign in_range_s = (sel_addr_s < 32'(MEM_DEPTH));
  assign rd_done_s  = (state_q == RD) && (cnt_q == 8'(READ_LAT - 1));

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({d_req, if_req}),
    .update (grant_s),
    .gnt    (gnt_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          if (!in_range_s)          state_d = RESP;
          else if (sel_d_s && d_we) state_d = WR;
          else                      state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (rd_done_s) state_d = RESP;
        else           state_d = RD;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; bus strobes decode the next state
  always_comb begin
    cnt_d        = cnt_q;
    win_d        = win_q;
    err_d        = err_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_adress_d = mem_adress_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          win_d = sel_d_s ? PORT_D : PORT_IF;
          err_d = !in_range_s;
          cnt_d = 8'd0;
          if (in_range_s) mem_adress_d = sel_addr_s;
          else            mem_adress_d = mem_adress_q;
          if (sel_d_s && d_we) mem_data_d = d_wdata;
          else                 mem_data_d = mem_data_q;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RD: begin
        cnt_d = cnt_q + 8'd1;
        if (rd_done_s) begin
          if (win_q == PORT_IF) if_rdata_d = mem_out;
          else                  d_rdata_d  = mem_out;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR: cnt_d = cnt_q;
      RESP: begin
        if (win_q == PORT_IF) begin
          if_ack_d = 1'b1;
          if_err_d = err_q;
        end else begin
          d_ack_d = 1'b1;
          d_err_d = err_q;
        end
      end
      default: cnt_d = 8'd0;
    endcase
    mem_read_d  = (state_d == RD);
    mem_write_d = (state_d == WR);
    busy_d      = (state_d != IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= 8'd0;
      win_q        <= PORT_IF;
      err_q        <= 1'b0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      mem_adress_q <= 32'd0;
      mem_data_q   <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      err_q        <= err_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_adress_q <= mem_adress_d;
      mem_data_q   <= mem_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;
  assign mem_adress = mem_adress_q;
  assign mem_data   = mem_data_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-feature tasks plus an ack monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MEM_DEPTH = 200;
  localparam int READ_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_adress, mem_data, mem_out;
  logic        mem_read, mem_write, busy;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_mem [MEM_DEPTH];
  logic [31:0] last_rd [2];
  logic [31:0] mem_model [MEM_DEPTH];
  bit          mem_init_done = 1'b0;
  logic        prev_if_ack = 1'b0;
  logic        prev_d_ack = 1'b0;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_adress(mem_adress), .mem_data(mem_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: word a initially holds 0xFC000000 | a
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < MEM_DEPTH; a++) mem_model[a] <= 32'hFC00_0000 | 32'(a);
      mem_init_done <= 1'b1;
    end else if (mem_write && (mem_adress < 32'(MEM_DEPTH))) begin
      mem_model[mem_adress[7:0]] <= mem_data;
    end
  end

  always_comb begin
    if (mem_adress < 32'(MEM_DEPTH)) mem_out = mem_model[mem_adress[7:0]];
    else                             mem_out = 32'h0;
  end

  // Ack monitor: pops the scoreboard and checks bus invariants
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (mem_read && mem_write) begin
        n_cmp++; n_fail++;
        $display("FAIL strobe_overlap: mem_read=1 mem_write=1, required not both");
      end
      if (if_ack && d_ack) begin
        n_cmp++; n_fail++;
        $display("FAIL ack_overlap: if_ack=1 d_ack=1, required not both");
      end
      if ((if_ack && prev_if_ack) || (d_ack && prev_d_ack)) begin
        n_cmp++; n_fail++;
        $display("FAIL ack_pulse: ack high two cycles, required one-cycle pulse");
      end
      if ((if_err && !if_ack) || (d_err && !d_ack)) begin
        n_cmp++; n_fail++;
        $display("FAIL err_outside_ack: if_err=%0b d_err=%0b without ack", if_err, d_err);
      end
      if (if_ack || d_ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b, required no ack", if_ack, d_ack);
        end else begin
          e = exp_q.pop_front();
          if ((e.port === PORT_D) !== (d_ack === 1'b1)) begin
            n_fail++;
            $display("FAIL ack_order: d_ack=%0b if_ack=%0b, required port %0d", d_ack, if_ack, e.port);
          end else if (e.port === PORT_D) begin
            if (d_err !== e.err || d_rdata !== e.rdata) begin
              n_fail++;
              $display("FAIL d_resp: err=%0b rdata=%h, required err=%0b rdata=%h", d_err, d_rdata, e.err, e.rdata);
            end
          end else begin
            if (if_err !== e.err || if_rdata !== e.rdata) begin
              n_fail++;
              $display("FAIL if_resp: err=%0b rdata=%h, required err=%0b rdata=%h", if_err, if_rdata, e.err, e.rdata);
            end
          end
        end
      end
    end
    prev_if_ack <= if_ack;
    prev_d_ack  <= d_ack;
  end

  task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name);
    exp_t e;
    int   cyc, nrd, nwr, exp_lat;
    logic valid, got;
    valid = (addr < 32'(MEM_DEPTH));
    e.port = port;
    e.err  = !valid;
    if (valid && !we) begin
      e.rdata = exp_mem[addr[7:0]];
      last_rd[port] = e.rdata;
    end else begin
      e.rdata = last_rd[port];
    end
    if (valid && we) exp_mem[addr[7:0]] = wdata;
    exp_lat = !valid ? 1 : (we ? 2 : READ_LAT + 1);
    @(negedge clk);
    exp_q.push_back(e);
    if (port == PORT_D) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    cyc = 0; nrd = 0; nwr = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) begin
        n_cmp++;
        if (mem_adress !== addr) begin
          n_fail++;
          $display("FAIL %s_adress: got %0d, required %0d", name, mem_adress, addr);
        end
      end
      if (mem_write) begin
        n_cmp++;
        if (mem_data !== wdata) begin
          n_fail++;
          $display("FAIL %s_wdata: got %h, required %h", name, mem_data, wdata);
        end
      end
      got = (port == PORT_D) ? d_ack : if_ack;
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: no ack after %0d cycles, required ack", name, cyc);
    end else if (cyc - 1 != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, required %0d", name, cyc - 1, exp_lat);
    end
    n_cmp++;
    if (nrd != ((valid && !we) ? READ_LAT : 0) || nwr != ((valid && we) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_strobes: read=%0d write=%0d, required read=%0d write=%0d", name, nrd, nwr,
               (valid && !we) ? READ_LAT : 0, (valid && we) ? 1 : 0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if (busy !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0 || if_err !== 1'b0 || d_err !== 1'b0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0 || mem_adress !== 32'd0 || mem_data !== 32'd0 ||
        if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: busy=%b acks=%b%b errs=%b%b rd=%b wr=%b adr=%h dat=%h ifr=%h dr=%h, required all 0",
               name, busy, if_ack, d_ack, if_err, d_err, mem_read, mem_write, mem_adress, mem_data, if_rdata, d_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    for (int a = 0; a < MEM_DEPTH; a++) exp_mem[a] = 32'hFC00_0000 | 32'(a);
    #1;
    check_idle_outputs("reset_t0");
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_round_robin();
    int   acks, cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.port  = (i % 2 == 0) ? PORT_IF : PORT_D;
      e.err   = 1'b0;
      e.rdata = exp_mem[(i % 2 == 0) ? 10 : 20];
      last_rd[e.port] = e.rdata;
      exp_q.push_back(e);
    end
    if_req = 1'b1; if_addr = 32'd10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd20;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_ack || d_ack) acks++;
    end
    if_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (acks != 4) begin
      n_fail++;
      $display("FAIL rr_acks: got %0d acks, required 4", acks);
    end
  endtask

  task automatic test_fetch_read();
    do_req(PORT_IF, 1'b0, 32'd107, 32'd0, "fetch107");
    n_cmp++;
    if (if_rdata !== 32'hFC00_006B) begin
      n_fail++;
      $display("FAIL fetch107_rdata: got %h, required fc00006b", if_rdata);
    end
  endtask

  task automatic test_data_write();
    do_req(PORT_D, 1'b1, 32'd105, 32'd5, "dwrite105");
    do_req(PORT_D, 1'b0, 32'd105, 32'd0, "dread105");
    do_req(PORT_IF, 1'b0, 32'd105, 32'd0, "fread105");
  endtask

  task automatic test_range_error();
    do_req(PORT_D, 1'b0, 32'd200, 32'd0, "derr200");
    do_req(PORT_D, 1'b1, 32'd500, 32'h1234, "derr_wr500");
    do_req(PORT_IF, 1'b0, 32'hFFFF_FFFF, 32'd0, "iferr_max");
    do_req(PORT_D, 1'b0, 32'd199, 32'd0, "dread199");
  endtask

  task automatic test_back_to_back();
    logic        port, we;
    logic [31:0] addr;
    for (int i = 0; i < 10; i++) begin
      port = 1'($urandom_range(0, 1));
      we   = (port == PORT_D) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = ($urandom_range(0, 7) == 0) ? 32'(200 + $urandom_range(0, 40)) : 32'($urandom_range(0, 199));
      do_req(port, we, addr, $urandom, "b2b");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'd50;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_rd: mem_read=%b, required 1", mem_read);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drop: mem_read=%b busy=%b, required 0 0", mem_read, busy);
    end
    if_req = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("midrst_held");
    reset = 1'b1;
    do_req(PORT_IF, 1'b0, 32'd50, 32'd0, "after_rst50");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fetch_read();
    test_data_write();
    test_range_error();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 200, number of addressable memory words.
REQ-002 SHALL have parameter READ_LAT, default 2, cycles mem_read is held before mem_out is sampled (min 1).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: instruction-fetch read request and word address.
REQ-006 SHALL have ports if_ack out 1, if_rdata out 32, if_err out 1: fetch completion pulse, read data, range error.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32: data request, 1=write, address, write data.
REQ-008 SHALL have ports d_ack out 1, d_rdata out 32, d_err out 1: data completion pulse, load data, range error.
REQ-009 SHALL have ports mem_adress out 32, mem_data out 32, mem_read out 1, mem_write out 1, mem_out in 32: memory-side bus.
REQ-010 SHALL have port busy  out 1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-012 In IDLE with any req high, SHALL latch winner's operands, record winner, go to RD (read) or WR (write) same edge; with no req, stay IDLE.
REQ-013 Requesters SHALL hold req and operands stable until ack; arbiter samples operands only at grant edge.
REQ-014 Tie (both req in IDLE) SHALL go to port not granted last (round-robin); single requester always wins.
REQ-015 RD SHALL drive mem_read=1, mem_write=0, mem_adress=latched address for exactly READ_LAT cycles, then capture mem_out into winner's rdata and go to RESP.
REQ-016 WR SHALL drive mem_write=1, mem_read=0, mem_adress, mem_data=latched wdata for exactly 1 cycle, then go to RESP.
REQ-017 RESP SHALL assert winner's ack for exactly one cycle, then return to IDLE; the other port's ack stays 0.
REQ-018 Read latency SHALL be grant edge + READ_LAT + 1 cycles to ack; write latency grant edge + 2 cycles.
REQ-019 mem_read and mem_write SHALL never be high together and SHALL be 0 in IDLE and RESP.
REQ-020 Address >= MEM_DEPTH SHALL go IDLE->RESP directly, assert ack with err=1, no memory strobe, rdata unchanged.
REQ-021 err outputs SHALL be high only during that port's ack cycle.
REQ-022 rdata outputs SHALL hold last captured value until next successful read on that port.
REQ-023 if_req with d_req pending in RESP SHALL not be evaluated until next IDLE cycle (one idle bubble per transaction).
REQ-024 Fetch port SHALL never cause a write.

Reset
REQ-025 reset low SHALL immediately force state IDLE, all acks/errs/strobes/busy 0, mem_adress/mem_data/rdata 0, last-grant = data port (fetch wins first tie).
REQ-026 Reset mid-transaction SHALL drop the transaction with no ack; requester must re-request.

Structure
REQ-027 Shared package SHALL hold FSM state enum, port index constants (PORT_IF=0, PORT_D=1), default MEM_DEPTH and READ_LAT.
REQ-028 Round-robin tie-break SHALL be one sub-module rr_arb2 (two requests, last-grant register, one-hot grant).

Verification
REQ-029 Fetch read addr 107, mem_out=0xFC00006B -> mem_read high 2 cycles at 107, if_ack at grant+3, if_rdata=0xFC00006B.
REQ-030 Data write addr 105 wdata 5 -> mem_write one cycle, mem_adress=105, mem_data=5, d_ack at grant+2, d_err=0.
REQ-031 Both req held from IDLE after reset -> fetch served first, data second, then fetch again (alternation over 4 grants).
REQ-032 d_addr=200 read -> d_ack+d_err at grant+1, no mem_read/mem_write pulse, d_rdata unchanged.
REQ-033 reset low during RD cycle 1 -> mem_read and busy drop same cycle, no ack; fresh request afterwards completes normally.
REQ-034 Assertion across all tests: never mem_read&&mem_write, never if_ack&&d_ack, ack always one-cycle pulse.
